// File: rtl/pool_patch_gen.sv
// pool_patch_gen
//   Converts a raster-order pixel stream into non-overlapping 2x2, stride-2
//   patches for the max-pool stage. Even-numbered rows are parked in a
//   one-row line buffer. On odd-numbered rows, the even-column pixel is held,
//   and each odd-column pixel completes a patch.
//
// Ports
//   CLK        rising-edge clock
//   rst_n      asynchronous active-low reset
//   clear      synchronous frame restart (drops any pending patch)
//   in_data    pixel value            in_valid / in_ready : input handshake
//   PATCH      {TL, TR, BL, BR}, TL in the MSBs
//   out_valid  PATCH valid            out_ready           : output handshake
//   out_last   PATCH is the bottom-right patch of the frame
module pool_patch_gen #(
  parameter int DATAWIDTH = 64,
  parameter int IMG_W     = 8,
  parameter int IMG_H     = 8
) (
  input  logic                   CLK,
  input  logic                   rst_n,
  input  logic                   clear,
  input  logic [DATAWIDTH-1:0]   in_data,
  input  logic                   in_valid,
  output logic                   in_ready,
  output logic [4*DATAWIDTH-1:0] PATCH,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic                   out_last
);

  localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);

  logic [CW-1:0]          col_q, col_d;
  logic [RW-1:0]          row_q, row_d;
  logic [DATAWIDTH-1:0]   held_q, held_d;
  logic [4*DATAWIDTH-1:0] patch_q, patch_d;
  logic                   out_valid_q, out_valid_d;
  logic                   out_last_q, out_last_d;
  logic [DATAWIDTH-1:0]   linebuf_q [IMG_W];

  logic          in_fire;
  logic          odd_row;
  logic          odd_col;
  logic [CW-1:0] col_prev;

  // Any beat stalls while an untaken patch is held. Stalling only on
  // patch-completing beats would also work, but this rule is simpler and
  // can never drop a patch.
  assign in_ready = !out_valid_q || out_ready;
  assign in_fire  = in_valid && in_ready;
  assign odd_row  = row_q[0];
  assign odd_col  = col_q[0];
  assign col_prev = col_q - CW'(1);

  always_comb begin
    col_d       = col_q;
    row_d       = row_q;
    held_d      = held_q;
    patch_d     = patch_q;
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;

    if (clear) begin
      col_d       = '0;
      row_d       = '0;
      out_valid_d = 1'b0;
      out_last_d  = 1'b0;
    end else begin
      if (out_valid_q && out_ready) begin
        out_valid_d = 1'b0;
        out_last_d  = 1'b0;
      end

      if (in_fire) begin
        if (col_q == COL_LAST) begin
          col_d = '0;
          row_d = (row_q == ROW_LAST) ? '0 : row_q + RW'(1);
        end else begin
          col_d = col_q + CW'(1);
        end

        if (odd_row && !odd_col) begin
          held_d = in_data;
        end

        // A completing beat overrides the clear above, so a taken patch
        // is replaced back-to-back with no bubble.
        if (odd_row && odd_col) begin
          patch_d     = {linebuf_q[col_prev], linebuf_q[col_q], held_q, in_data};
          out_valid_d = 1'b1;
          out_last_d  = (row_q == ROW_LAST) && (col_q == COL_LAST);
        end
      end
    end
  end

  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      col_q       <= '0;
      row_q       <= '0;
      held_q      <= '0;
      patch_q     <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
    end else begin
      col_q       <= col_d;
      row_q       <= row_d;
      held_q      <= held_d;
      patch_q     <= patch_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
    end
  end

  // The line buffer holds data only and has no reset. The odd row reads
  // entries col-1 and col before the next even row rewrites them.
  always_ff @(posedge CLK) begin
    if (in_fire && !clear && !odd_row) begin
      linebuf_q[col_q] <= in_data;
    end
  end

  assign PATCH     = patch_q;
  assign out_valid = out_valid_q;
  assign out_last  = out_last_q;

endmodule

// File: tb/tb_pool_patch_gen.sv
module tb_pool_patch_gen;

  localparam int DW = 16;
  localparam int W  = 4;
  localparam int H  = 4;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            clear;
  logic [DW-1:0]   in_data;
  logic            in_valid;
  logic            in_ready;
  logic [4*DW-1:0] patch;
  logic            out_valid;
  logic            out_ready = 1'b1;
  logic            out_last;

  always #5 clk = ~clk;

  pool_patch_gen #(.DATAWIDTH(DW), .IMG_W(W), .IMG_H(H)) dut (
    .CLK      (clk),
    .rst_n    (rst_n),
    .clear    (clear),
    .in_data  (in_data),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .PATCH    (patch),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_last (out_last)
  );

  typedef struct packed {
    logic [4*DW-1:0] p;
    logic            l;
  } exp_t;

  exp_t          sbq[$];
  exp_t          mon_e;
  int            total = 0, bad = 0;
  int            mon_total = 0, mon_bad = 0;
  int            deliv = 0, lasts = 0;
  logic          force_rdy = 1'b1;
  logic          rand_rdy  = 1'b0;
  logic [DW-1:0] pix [H][W];

  // Downstream ready driver; updates 2 time units after each rising edge.
  always @(posedge clk) begin
    #2;
    out_ready = rand_rdy ? 1'($urandom_range(0, 1)) : force_rdy;
  end

  // Monitor: every accepted patch is checked against the head of the queue.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      deliv++;
      if (out_last) lasts++;
      mon_total++;
      if (sbq.size() == 0) begin
        mon_bad++;
        $display("FAIL unexpected_patch: got %h last=%b, none expected", patch, out_last);
      end else begin
        mon_e = sbq.pop_front();
        if (patch !== mon_e.p || out_last !== mon_e.l) begin
          mon_bad++;
          $display("FAIL patch_%0d: got %h last=%b, expected %h last=%b",
                   deliv, patch, out_last, mon_e.p, mon_e.l);
        end
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, expv);
    end
  endtask

  // Enters and leaves 1 time unit after a rising edge.
  task automatic send_pix(input logic [DW-1:0] v, input int gap);
    int   n;
    logic acc;
    if (gap > 0) begin
      in_valid = 1'b0;
      repeat (gap) @(posedge clk);
      #1;
    end
    in_data  = v;
    in_valid = 1'b1;
    n   = 0;
    acc = 1'b0;
    while (!acc && n < 500) begin
      @(negedge clk);
      acc = in_ready;
      n++;
    end
    if (!acc) begin
      total++;
      bad++;
      $display("FAIL accept_timeout: pixel %h not accepted after %0d cycles", v, n);
    end else begin
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
  endtask

  task automatic push_tile(input int r, input int c);
    exp_t e;
    e.p = {pix[r-1][c-1], pix[r-1][c], pix[r][c-1], pix[r][c]};
    e.l = (r == H-1) && (c == W-1);
    sbq.push_back(e);
  endtask

  task automatic send_idx(input int i, input logic [DW-1:0] v, input int gap);
    int r, c;
    r = i / W;
    c = i % W;
    pix[r][c] = v;
    send_pix(v, gap);
    if ((r % 2 == 1) && (c % 2 == 1)) push_tile(r, c);
  endtask

  task automatic send_frame(input logic [DW-1:0] base, input int maxgap, input bit rnd);
    for (int i = 0; i < W*H; i++) begin
      send_idx(i, rnd ? DW'($urandom) : base + DW'(i), $urandom_range(0, maxgap));
    end
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while (sbq.size() != 0 && n < 400) begin
      @(posedge clk);
      n++;
    end
    chk({name, "_pending"}, 64'(sbq.size()), 64'd0);
    repeat (2) @(posedge clk);
    #1;
    chk({name, "_idle_valid"}, 64'(out_valid), 64'd0);
  endtask

  int d0, l0;

  initial begin
    rst_n    = 1'b0;
    clear    = 1'b0;
    in_valid = 1'b0;
    in_data  = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_valid", 64'(out_valid), 64'd0);
    chk("reset_last", 64'(out_last), 64'd0);
    chk("reset_patch", patch, 64'd0);
    chk("reset_in_ready", 64'(in_ready), 64'd1);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Back-to-back frame 1..16, downstream always ready.
    d0 = deliv;
    for (int i = 0; i < W*H; i++) begin
      send_idx(i, DW'(i + 1), 0);
      if (i == 5) begin
        chk("t1_first_valid", 64'(out_valid), 64'd1);
        chk("t1_first_patch", patch, 64'h0001_0002_0005_0006);
        chk("t1_first_last", 64'(out_last), 64'd0);
      end
      if (i == 15) begin
        chk("t1_final_valid", 64'(out_valid), 64'd1);
        chk("t1_final_patch", patch, 64'h000b_000c_000f_0010);
        chk("t1_final_last", 64'(out_last), 64'd1);
      end
    end
    drain("t1");
    chk("t1_count", 64'(deliv - d0), 64'd4);

    // Downstream stall right after the first patch.
    d0 = deliv;
    for (int i = 0; i < 5; i++) send_idx(i, DW'(i + 1), 0);
    force_rdy = 1'b0;
    send_idx(5, DW'(6), 0);
    in_data  = DW'(7);
    in_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("t2_stall_in_ready", 64'(in_ready), 64'd0);
      chk("t2_stall_patch", {patch[63:1], out_valid}, {64'h0001_0002_0005_0006 >> 1, 1'b1} );
    end
    force_rdy = 1'b1;
    for (int i = 6; i < W*H; i++) send_idx(i, DW'(i + 1), 0);
    drain("t2");
    chk("t2_count", 64'(deliv - d0), 64'd4);

    // Two back-to-back frames with random input gaps.
    d0 = deliv;
    l0 = lasts;
    send_frame(DW'(16'h10), 2, 1'b0);
    send_frame(DW'(16'h20), 2, 1'b0);
    drain("t3");
    chk("t3_count", 64'(deliv - d0), 64'd8);
    chk("t3_lasts", 64'(lasts - l0), 64'd2);

    // clear discards a pending patch and restarts the frame.
    d0 = deliv;
    for (int i = 0; i < 5; i++) send_idx(i, DW'(16'h50 + i), 0);
    force_rdy = 1'b0;
    send_idx(5, DW'(16'h55), 0);
    void'(sbq.pop_back());
    clear = 1'b1;
    @(posedge clk);
    #1;
    clear = 1'b0;
    chk("t4_clear_valid", 64'(out_valid), 64'd0);
    chk("t4_clear_in_ready", 64'(in_ready), 64'd1);
    force_rdy = 1'b1;
    send_frame(DW'(1), 0, 1'b0);
    drain("t4");
    chk("t4_count", 64'(deliv - d0), 64'd4);

    // Asynchronous reset while a patch is pending.
    d0 = deliv;
    for (int i = 0; i < 5; i++) send_idx(i, DW'(16'h60 + i), 0);
    force_rdy = 1'b0;
    send_idx(5, DW'(16'h65), 0);
    #1;
    rst_n = 1'b0;
    #1;
    chk("t5_rst_valid", 64'(out_valid), 64'd0);
    chk("t5_rst_last", 64'(out_last), 64'd0);
    chk("t5_rst_patch", patch, 64'd0);
    void'(sbq.pop_back());
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    force_rdy = 1'b1;
    send_frame(DW'(16'h30), 1, 1'b0);
    drain("t5");
    chk("t5_count", 64'(deliv - d0), 64'd4);

    // Random downstream ready over many frames of random pixel values.
    d0 = deliv;
    l0 = lasts;
    rand_rdy = 1'b1;
    for (int f = 0; f < 100; f++) send_frame(DW'(0), 1, 1'b1);
    drain("t6");
    rand_rdy = 1'b0;
    chk("t6_count", 64'(deliv - d0), 64'd400);
    chk("t6_lasts", 64'(lasts - l0), 64'd100);

    total += mon_total;
    bad   += mon_bad;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pool_patch_gen.md
Name: pool_patch_gen

Overview:
- Streaming producer for the 2x2 max-pool datapath.
- Accepts a raster-order pixel stream (row-major, one pixel per beat) and buffers one image row.
- Emits non-overlapping 2x2, stride-2 patches packed in the 4*DATAWIDTH PATCH format consumed by maxpool.
- Sits between the feature-map source (DMA/conv output) and the pooling stage; handles valid/ready backpressure on both sides.

Parameters:
DATAWIDTH, 64, bits per pixel
IMG_W, 8, pixels per row; must be even and >= 2
IMG_H, 8, rows per frame; must be even and >= 2

Ports:
CLK  input  1  clock, all logic rising-edge
rst_n  input  1  asynchronous active-low reset
clear  input  1  synchronous frame restart; zeroes counters, drops pending output
in_data  input  DATAWIDTH  pixel value
in_valid  input  1  in_data valid
in_ready  output  1  block can accept a pixel this cycle
PATCH  output  4*DATAWIDTH  {P0,P1,P2,P3}, P0 in MSBs; P0=top-left, P1=top-right, P2=bottom-left, P3=bottom-right
out_valid  output  1  PATCH valid
out_ready  input  1  downstream accepts PATCH
out_last  output  1  qualifies PATCH as last patch of frame (bottom-right of image)

Behaviour:
- Reset (rst_n low, async): col=0, row=0, out_valid=0, out_last=0, PATCH=0, held-pixel reg=0. in_ready comes out of reset high. Line buffer contents are don't-care.
- Counters: col in 0..IMG_W-1, row in 0..IMG_H-1, advance only on in_fire = in_valid & in_ready.
  - col wraps to 0 after IMG_W-1, and row increments at that point.
  - row wraps to 0 after IMG_H-1 at the last column; the next frame follows back-to-back with no gap cycle.
- Even row (row[0]=0): the accepted pixel is written to linebuf[col]. No output.
- Odd row, even col: the accepted pixel is stored in the held register (bottom-left). No output.
- Odd row, odd col: on in_fire, the output register loads:
  - PATCH = {linebuf[col-1], linebuf[col], held, in_data}
  - out_valid = 1
  - out_last = (row==IMG_H-1 && col==IMG_W-1)
- Latency: PATCH is valid the cycle after the bottom-right pixel is accepted.
- Output handshake:
  - PATCH and out_last are held stable while out_valid & !out_ready.
  - out_valid clears on out_ready unless a new patch loads in the same cycle.
- in_ready = !out_valid | out_ready.
  - Stalls are applied on every beat, not only on patch-completing beats. This keeps the rule simple and guarantees no patch is lost.
  - Simultaneous out_ready and patch-completing in_fire: the old patch is taken and the new patch loads in the same cycle, so out_valid stays 1.
- Throughput: one pixel per cycle with out_ready held high. Patch rate is 1 per 4 pixels on average, bursting 1 per 2 cycles during odd rows.
- Line buffer:
  - IMG_W entries x DATAWIDTH. Only even-indexed rows write it.
  - The odd row reads the two entries at col-1 and col before the next even row overwrites them, so a single row buffer suffices.
- clear (synchronous, priority over in_fire): col=0, row=0, out_valid=0, out_last=0. in_ready is high the next cycle. An undelivered patch is discarded.
- Reset mid-frame: same as clear, but asynchronous; the partial frame is lost.
- in_valid low mid-row: counters hold; gaps of any length are allowed.
- Arithmetic: no value processing; pixels pass bit-exact. Counter widths are $clog2 of IMG_W and IMG_H, minimum 1 bit.

Test Plan:
- IMG_W=4, IMG_H=2, out_ready=1, pixels 1..8 back-to-back -> PATCH {1,2,5,6} one cycle after pixel 6 (out_last=0); {3,4,7,8} one cycle after pixel 8 (out_last=1); exactly 2 patches.
- Same stream with out_ready=0 for 5 cycles after the first patch -> PATCH {1,2,5,6} held stable, in_ready=0 during the stall. After release, {3,4,7,8} is delivered; no loss or duplication.
- IMG_W=4, IMG_H=4, two consecutive frames of values 0x10..0x1F then 0x20..0x2F, random in_valid gaps -> 8 patches total. Frame 2's first patch = {0x20,0x21,0x24,0x25}; out_last on patches 4 and 8 only.
- Assert clear after pixel 5 of frame 1, then send 1..8 -> first patch is {1,2,5,6}; no stale patch appears.
- Deassert rst_n asynchronously while out_valid=1 -> out_valid, out_last and PATCH go to 0 immediately. The subsequent frame produces correct patches.
- Random out_ready (50%) over 100 frames of IMG_W=8, IMG_H=8 -> scoreboard matches a reference 2x2 tiling; 16 patches per frame; out_last is set once per frame.
